// File: rtl/ir_transmit_if.sv
// Start/data request and line outputs of the NEC IR transmitter.
interface ir_transmit_if;
  logic        iSTART;
  logic [31:0] iDATA;
  logic        oBUSY;
  logic        oDONE;
  logic        oIRDA;
  logic        oIR_TX;

  modport master (output iSTART, iDATA, input oBUSY, oDONE, oIRDA, oIR_TX);
  modport slave  (input iSTART, iDATA, output oBUSY, oDONE, oIRDA, oIR_TX);
endinterface

// File: rtl/ir_transmit.sv
// NEC IR frame transmitter: leader, 32 data bits LSB first, stop burst, enforced gap.
// Drives the demodulated line level (idle high) and a 38 kHz modulated LED output.
module ir_transmit #(
  parameter int unsigned LEAD_LOW_DUR  = 450000,
  parameter int unsigned LEAD_HIGH_DUR = 225000,
  parameter int unsigned BURST_DUR     = 28000,
  parameter int unsigned ZERO_HIGH_DUR = 28000,
  parameter int unsigned ONE_HIGH_DUR  = 84500,
  parameter int unsigned GAP_DUR       = 2000000,
  parameter int unsigned CARRIER_HALF  = 658,
  parameter int unsigned CARRIER_EN    = 1
) (
  input  logic         iCLK,
  input  logic         iRST_n,
  ir_transmit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, LEAD_LOW, LEAD_HIGH, BIT_LOW, BIT_HIGH, STOP_LOW, GAP
  } state_t;

  localparam logic [20:0] LL_LAST   = 21'(LEAD_LOW_DUR - 1);
  localparam logic [20:0] LH_LAST   = 21'(LEAD_HIGH_DUR - 1);
  localparam logic [20:0] BU_LAST   = 21'(BURST_DUR - 1);
  localparam logic [20:0] ZH_LAST   = 21'(ZERO_HIGH_DUR - 1);
  localparam logic [20:0] OH_LAST   = 21'(ONE_HIGH_DUR - 1);
  localparam logic [20:0] GAP_LAST  = 21'(GAP_DUR - 1);
  localparam logic [10:0] CAR_LAST  = 11'(CARRIER_HALF - 1);

  state_t      state_q, state_d;
  logic [20:0] cnt_q, cnt_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] shift_q, shift_d;
  logic [10:0] car_cnt_q, car_cnt_d;
  logic        car_q, car_d;
  logic        irda_q, irda_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [20:0] dur_last;
  logic        phase_end;
  logic        entering;
  logic        mark_d;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      car_cnt_q <= '0;
      car_q     <= 1'b0;
      irda_q    <= 1'b1;
      tx_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      car_cnt_q <= car_cnt_d;
      car_q     <= car_d;
      irda_q    <= irda_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    dur_last = '0;
    unique case (state_q)
      LEAD_LOW:  dur_last = LL_LAST;
      LEAD_HIGH: dur_last = LH_LAST;
      BIT_LOW:   dur_last = BU_LAST;
      BIT_HIGH:  dur_last = shift_q[0] ? OH_LAST : ZH_LAST;
      STOP_LOW:  dur_last = BU_LAST;
      GAP:       dur_last = GAP_LAST;
      default:   dur_last = '0;
    endcase
    phase_end = (cnt_q == dur_last);

    state_d = state_q;
    unique case (state_q)
      IDLE:      if (bus.iSTART) state_d = LEAD_LOW;
      LEAD_LOW:  if (phase_end)  state_d = LEAD_HIGH;
      LEAD_HIGH: if (phase_end)  state_d = BIT_LOW;
      BIT_LOW:   if (phase_end)  state_d = BIT_HIGH;
      BIT_HIGH:  if (phase_end)  state_d = (idx_q == 6'd31) ? STOP_LOW : BIT_LOW;
      STOP_LOW:  if (phase_end)  state_d = GAP;
      GAP:       if (phase_end)  state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    entering = (state_d != state_q);
    mark_d   = (state_d == LEAD_LOW) || (state_d == BIT_LOW) || (state_d == STOP_LOW);

    cnt_d = (entering || state_q == IDLE) ? '0 : cnt_q + 21'd1;

    shift_d = shift_q;
    idx_d   = idx_q;
    if (state_q == IDLE && bus.iSTART) begin
      shift_d = bus.iDATA;
      idx_d   = '0;
    end else if (state_q == BIT_HIGH && phase_end) begin
      shift_d = shift_q >> 1;
      idx_d   = idx_q + 6'd1;
    end

    car_cnt_d = '0;
    car_d     = 1'b0;
    if (mark_d && entering) begin
      car_cnt_d = '0;
      car_d     = 1'b1;
    end else if (mark_d) begin
      if (car_cnt_q == CAR_LAST) begin
        car_cnt_d = '0;
        car_d     = ~car_q;
      end else begin
        car_cnt_d = car_cnt_q + 11'd1;
        car_d     = car_q;
      end
    end

    irda_d = ~mark_d;
    tx_d   = mark_d & ((CARRIER_EN != 0) ? car_d : 1'b1);
    busy_d = (state_d != IDLE);
    done_d = (state_q == GAP) && (state_d == IDLE);
  end

  assign bus.oIRDA  = irda_q;
  assign bus.oIR_TX = tx_q;
  assign bus.oBUSY  = busy_q;
  assign bus.oDONE  = done_q;

endmodule
